// File: rtl/waveform_scroller_pkg.sv
// Shared constants, scan bundle and freeze FSM states for the waveform scroller.
package waveform_scroller_pkg;

    localparam int DEPTH    = 1024;  // buffer entries = visible columns
    localparam int AW       = 10;    // log2(DEPTH)
    localparam int DECIM    = 4;     // keep 1 of every DECIM valid samples
    localparam int LAT      = 2;     // hcount_in -> signal_out latency
    localparam int SAMPLE_W = 9;
    localparam int HC_W     = 11;
    localparam int VC_W     = 10;
    localparam int H_ACTIVE = 1024;
    localparam int V_ACTIVE = 768;

    // Scan position travelling alongside the read data
    typedef struct packed {
        logic [HC_W-1:0] hcount;
        logic [VC_W-1:0] vcount;
        logic            blank;
    } scan_t;

    localparam scan_t SCAN_RST = '{hcount: '0, vcount: '0, blank: 1'b1};

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HOLD_PEND = 2'd1,
        ST_FROZEN    = 2'd2
    } frz_state_t;

    function automatic logic is_frame_start(input logic [HC_W-1:0] h, input logic [VC_W-1:0] v);
        return (h == '0) && (v == '0);
    endfunction

endpackage

// File: rtl/waveform_scroller_bram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// Read-first: a read and write to the same address in one cycle returns the old word.
module wave_bram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int W     = 9
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    // Write and registered read share the edge; NBA ordering gives read-first
    always_ff @(posedge clock) begin
        if (we)
            mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/waveform_scroller.sv
// Scrolling sample store + scan-synchronous replay for the waveform renderer.
// Optional display hold is compiled in with `define WAVEFORM_FREEZE_EN.
module waveform_scroller
    import waveform_scroller_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid,
    input  logic [HC_W-1:0]            hcount_in,
    input  logic [VC_W-1:0]            vcount_in,
    input  logic                       blank_in,
    input  logic                       freeze,
    output logic signed [SAMPLE_W-1:0] signal_out,
    output logic [HC_W-1:0]            hcount_out,
    output logic [VC_W-1:0]            vcount_out,
    output logic                       blank_out,
    output logic                       frozen
);

    logic                frame_start;
    logic                accept;
    logic                wr_en;
    logic [7:0]          decim_cnt;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       frame_base;
    logic [AW-1:0]       rd_base;
    logic [AW-1:0]       rd_addr;
    logic [SAMPLE_W-1:0] rd_data;
    scan_t               scan_in;
    scan_t               scan_d1;
    scan_t               scan_q;
    logic                col_ok_d1;

    assign frame_start = is_frame_start(hcount_in, vcount_in);

`ifdef WAVEFORM_FREEZE_EN
    frz_state_t state;

    // Hold request arms in RUN, takes effect at the next frame start, releases at a frame start
    always_ff @(posedge clock) begin
        if (reset)
            state <= ST_RUN;
        else begin
            unique case (state)
                ST_RUN:       if (freeze) state <= ST_HOLD_PEND;
                ST_HOLD_PEND: if (!freeze) state <= ST_RUN;
                              else if (frame_start) state <= ST_FROZEN;
                ST_FROZEN:    if (frame_start && !freeze) state <= ST_RUN;
                default:      state <= ST_RUN;
            endcase
        end
    end

    assign accept = sample_valid && (state != ST_FROZEN);
    assign frozen = (state == ST_FROZEN);
`else
    logic unused_freeze;
    assign unused_freeze = freeze;
    assign accept        = sample_valid;
    assign frozen        = 1'b0;
`endif

    assign wr_en = accept && (decim_cnt == 8'(DECIM - 1)) && !reset;

    // Decimator, write pointer and per-frame base latch (base takes the pre-increment pointer)
    always_ff @(posedge clock) begin
        if (reset) begin
            decim_cnt  <= '0;
            wr_ptr     <= '0;
            frame_base <= '0;
        end else begin
            if (accept)
                decim_cnt <= wr_en ? 8'd0 : decim_cnt + 8'd1;
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (frame_start)
                frame_base <= wr_ptr;
        end
    end

    // Column 0 of a new frame must already use the base being latched this cycle
    assign rd_base = frame_start ? wr_ptr : frame_base;
    assign rd_addr = rd_base + hcount_in[AW-1:0];

    wave_bram #(.DEPTH(DEPTH), .AW(AW), .W(SAMPLE_W)) u_bram (
        .clock   (clock),
        .we      (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (sample_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign scan_in = '{hcount: hcount_in, vcount: vcount_in, blank: blank_in};

    // Two-stage delay: scan info and column gate track the RAM read, then the output register
    always_ff @(posedge clock) begin
        if (reset) begin
            scan_d1    <= SCAN_RST;
            col_ok_d1  <= 1'b0;
            scan_q     <= SCAN_RST;
            signal_out <= '0;
        end else begin
            scan_d1    <= scan_in;
            col_ok_d1  <= (hcount_in < HC_W'(DEPTH));
            scan_q     <= scan_d1;
            signal_out <= col_ok_d1 ? $signed(rd_data) : '0;
        end
    end

    assign hcount_out = scan_q.hcount;
    assign vcount_out = scan_q.vcount;
    assign blank_out  = scan_q.blank;

endmodule

// File: tb/tb_waveform_scroller.sv
// Randomized bench for waveform_scroller with a behavioural scan/buffer model.
module tb_waveform_scroller;

    localparam int D  = 1024;
    localparam int DC = 4;
    localparam logic [30:0] RST_OUT = {9'd0, 11'd0, 10'd0, 1'b1};

    logic              clock;
    logic              reset;
    logic signed [8:0] sample_in;
    logic              sample_valid;
    logic [10:0]       hcount_in;
    logic [9:0]        vcount_in;
    logic              blank_in;
    logic              freeze;
    logic signed [8:0] signal_out;
    logic [10:0]       hcount_out;
    logic [9:0]        vcount_out;
    logic              blank_out;
    logic              frozen;

    waveform_scroller dut (
        .clock(clock), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .blank_in(blank_in), .freeze(freeze),
        .signal_out(signal_out), .hcount_out(hcount_out), .vcount_out(vcount_out),
        .blank_out(blank_out), .frozen(frozen)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: sample buffer as an array, counts of accepted samples
    logic [8:0]  m_mem [D];
    int          m_nacc, m_wr, m_base;
    logic [8:0]  m_last;
    logic        m_frozen, m_pend;
    logic [30:0] prev_exp, exp_out, obs;
    logic        obs_frozen;
    int          n_checks, n_errors;

    // One clock: apply inputs, advance the model, sample outputs 1 time unit after the edge
    task automatic cyc(input logic v, input logic [8:0] s, input logic [10:0] h,
                       input logic [9:0] vc, input logic b, input logic rst, input logic frz);
        logic        fs;
        int          base_now;
        logic [8:0]  rd;
        logic [30:0] cur;
        reset = rst; sample_valid = v; sample_in = s; hcount_in = h;
        vcount_in = vc; blank_in = b; freeze = frz;
        fs = (h == 11'd0) && (vc == 10'd0);
        if (rst) begin
            m_nacc = 0; m_wr = 0; m_base = 0; m_frozen = 1'b0; m_pend = 1'b0;
            cur = RST_OUT;
        end else begin
            base_now = fs ? m_wr : m_base;
            rd  = (int'(h) < D) ? m_mem[(base_now + int'(h)) % D] : 9'd0;
            cur = {rd, h, vc, b};
            if (v && !m_frozen) begin
                m_nacc++;
                if (m_nacc % DC == 0) begin
                    m_mem[m_wr] = s;
                    m_last = s;
                    m_wr = (m_wr + 1) % D;
                end
            end
            if (fs) m_base = base_now;
`ifdef WAVEFORM_FREEZE_EN
            if (!m_frozen) begin
                if (m_pend && frz && fs) begin m_frozen = 1'b1; m_pend = 1'b0; end
                else m_pend = frz;
            end else if (fs && !frz) m_frozen = 1'b0;
`endif
        end
        @(posedge clock);
        #1;
        exp_out  = rst ? RST_OUT : prev_exp;
        prev_exp = cur;
        obs = {signal_out, hcount_out, vcount_out, blank_out};
        obs_frozen = frozen;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 9'd0, 11'd700, 10'd9, 1'b0, 1'b1, 1'b0);
            n_checks++;
            if (obs !== RST_OUT) begin n_errors++; $display("FAIL reset_out: got %h want %h", obs, RST_OUT); end
            n_checks++;
            if (obs_frozen !== 1'b0) begin n_errors++; $display("FAIL reset_frozen: got %b want 0", obs_frozen); end
        end
        cyc(1'b0, 9'd0, 11'd1100, 10'd800, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (obs !== RST_OUT) begin n_errors++; $display("FAIL reset_stage1: got %h want %h", obs, RST_OUT); end
    endtask

    // Fill all 1024 entries with every 4th of k%256, then scan a frame starting at base 0
    task automatic test_fill();
        for (int k = 0; k < 4096; k++) begin
            cyc(1'b1, 9'(k % 256), 11'd1100, 10'd800, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (obs !== exp_out) begin n_errors++; $display("FAIL fill_gate: got %h want %h", obs, exp_out); end
        end
        for (int c = 0; c < 1032; c++) begin
            cyc(1'b0, 9'd0, 11'(c), 10'd0, c >= 1024, 1'b0, 1'b0);
            n_checks++;
            if (obs !== exp_out) begin n_errors++; $display("FAIL fill_scan: got %h want %h", obs, exp_out); end
            if (c >= 1 && c <= 1024) begin
                n_checks++;
                if (obs[30:22] !== 9'(((c - 1) * 4 + 3) % 256))
                    begin n_errors++; $display("FAIL fill_decim col %0d: got %0d want %0d", c - 1, obs[30:22], ((c - 1) * 4 + 3) % 256); end
            end
        end
    endtask

    // Samples pushed mid-line; next frame shows newest sample at column 1023
    task automatic test_scroll();
        for (int c = 0; c < 1344; c++) begin
            cyc(1'($urandom_range(0, 1)), 9'($urandom), 11'(c), 10'd1, c >= 1024, 1'b0, 1'b0);
            n_checks++;
            if (obs !== exp_out) begin n_errors++; $display("FAIL scroll_line: got %h want %h", obs, exp_out); end
        end
        for (int c = 0; c < 1026; c++) begin
            cyc(1'b0, 9'd0, 11'(c), 10'd0, c >= 1024, 1'b0, 1'b0);
            n_checks++;
            if (obs !== exp_out) begin n_errors++; $display("FAIL scroll_frame: got %h want %h", obs, exp_out); end
            if (c == 1024) begin
                n_checks++;
                if (obs[30:22] !== m_last) begin n_errors++; $display("FAIL scroll_newest: got %h want %h", obs[30:22], m_last); end
            end
        end
    endtask

    // Random scan jumps, frame starts and write/read collisions
    task automatic test_random();
        logic [10:0] h;
        for (int i = 0; i < 1500; i++) begin
            h = ($urandom_range(0, 15) == 0) ? 11'd0 : 11'($urandom_range(0, 1343));
            cyc(1'($urandom_range(0, 1)), 9'($urandom), h, 10'($urandom_range(0, 2)), h >= 11'd1024, 1'b0, 1'b0);
            n_checks++;
            if (obs !== exp_out) begin n_errors++; $display("FAIL random_scan: got %h want %h", obs, exp_out); end
        end
    endtask

    // Frame start in the same cycle as the decimated write
    task automatic test_coincide();
        for (int i = 0; i < 8 && (m_nacc % DC) != DC - 1; i++)
            cyc(1'b1, 9'($urandom), 11'd1100, 10'd800, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 9'h155, 11'd0, 10'd0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c < 1026; c++) begin
            cyc(1'b0, 9'd0, 11'(c), 10'd1, c >= 1024, 1'b0, 1'b0);
            n_checks++;
            if (obs !== exp_out) begin n_errors++; $display("FAIL coincide_line: got %h want %h", obs, exp_out); end
        end
        for (int c = 0; c < 1026; c++) begin
            cyc(1'b0, 9'd0, 11'(c), 10'd0, c >= 1024, 1'b0, 1'b0);
            n_checks++;
            if (obs !== exp_out) begin n_errors++; $display("FAIL coincide_frame: got %h want %h", obs, exp_out); end
            if (c == 1024) begin
                n_checks++;
                if (obs[30:22] !== 9'h155) begin n_errors++; $display("FAIL coincide_col1023: got %h want 155", obs[30:22]); end
            end
        end
    endtask

`ifdef WAVEFORM_FREEZE_EN
    task automatic test_freeze();
        logic [8:0] snap [D];
        int sb;
        for (int c = 0; c < 20; c++) begin
            cyc(1'b0, 9'd0, 11'(c), 10'd300, 1'b0, 1'b0, 1'b1);
            n_checks++;
            if (obs_frozen !== 1'b0) begin n_errors++; $display("FAIL freeze_pend: got %b want 0", obs_frozen); end
        end
        snap = m_mem; sb = m_wr;
        cyc(1'b0, 9'd0, 11'd0, 10'd0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (obs_frozen !== 1'b1) begin n_errors++; $display("FAIL freeze_enter: got %b want 1", obs_frozen); end
        for (int i = 0; i < 2000; i++)
            cyc(1'b1, 9'($urandom), 11'd1100, 10'd800, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (obs_frozen !== 1'b1) begin n_errors++; $display("FAIL freeze_hold: got %b want 1", obs_frozen); end
        for (int c = 0; c < 1026; c++) begin
            cyc(1'b0, 9'd0, 11'(c), 10'd0, c >= 1024, 1'b0, 1'b1);
            if (c >= 1 && c <= 1024) begin
                n_checks++;
                if (obs[30:22] !== snap[(sb + c - 1) % D])
                    begin n_errors++; $display("FAIL freeze_image col %0d: got %h want %h", c - 1, obs[30:22], snap[(sb + c - 1) % D]); end
            end
        end
        for (int c = 0; c < 10; c++) begin
            cyc(1'b0, 9'd0, 11'(c + 1), 10'd5, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs_frozen !== 1'b1) begin n_errors++; $display("FAIL freeze_release_wait: got %b want 1", obs_frozen); end
        end
        cyc(1'b0, 9'd0, 11'd0, 10'd0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_frozen !== 1'b0) begin n_errors++; $display("FAIL freeze_exit: got %b want 0", obs_frozen); end
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 9'($urandom), 11'd1100, 10'd800, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 1026; c++) begin
            cyc(1'b0, 9'd0, 11'(c), 10'd0, c >= 1024, 1'b0, 1'b0);
            n_checks++;
            if (obs !== exp_out) begin n_errors++; $display("FAIL freeze_resume: got %h want %h", obs, exp_out); end
        end
    endtask
`else
    task automatic test_freeze();
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 9'($urandom), 11'd1100, 10'd800, 1'b1, 1'b0, 1'b1);
            n_checks++;
            if (obs_frozen !== 1'b0) begin n_errors++; $display("FAIL freeze_absent: got %b want 0", obs_frozen); end
        end
        for (int c = 0; c < 1026; c++) begin
            cyc(1'b0, 9'd0, 11'(c), 10'd0, c >= 1024, 1'b0, 1'b1);
            n_checks++;
            if (obs !== exp_out) begin n_errors++; $display("FAIL freeze_ignored: got %h want %h", obs, exp_out); end
            if (c == 1024) begin
                n_checks++;
                if (obs[30:22] !== m_last) begin n_errors++; $display("FAIL freeze_newest: got %h want %h", obs[30:22], m_last); end
            end
        end
    endtask
`endif

    // Reset in the middle of a line, then read restarts from base 0
    task automatic test_reset_mid();
        for (int c = 0; c < 500; c++) begin
            cyc(1'($urandom_range(0, 1)), 9'($urandom), 11'(c), 10'd2, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs !== exp_out) begin n_errors++; $display("FAIL pre_reset: got %h want %h", obs, exp_out); end
        end
        cyc(1'b0, 9'd0, 11'd500, 10'd2, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (obs !== RST_OUT) begin n_errors++; $display("FAIL reset_mid: got %h want %h", obs, RST_OUT); end
        cyc(1'b0, 9'd0, 11'd600, 10'd2, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs !== RST_OUT) begin n_errors++; $display("FAIL reset_mid_stage1: got %h want %h", obs, RST_OUT); end
        for (int c = 0; c < 40; c++) begin
            cyc(1'b0, 9'd0, 11'(c), 10'd3, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs !== exp_out) begin n_errors++; $display("FAIL reset_base0: got %h want %h", obs, exp_out); end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_errors = 0;
        m_nacc = 0; m_wr = 0; m_base = 0; m_last = '0;
        m_frozen = 1'b0; m_pend = 1'b0; prev_exp = RST_OUT;
        for (int i = 0; i < D; i++) m_mem[i] = '0;
        reset = 1'b1; sample_valid = 1'b0; sample_in = '0; hcount_in = '0;
        vcount_in = '0; blank_in = 1'b1; freeze = 1'b0;
        test_reset();
        test_fill();
        test_scroll();
        test_random();
        test_coincide();
        test_freeze();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
